// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : LEGv8 fetch-and-branch controller. Owns the PC and resolves
//            B/BL/CBZ/CBNZ/B.cond/BR in decode, squashing one wrong-path slot.
// Revision : 1.0
// ============================================================================
module pc_sequencer #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instr,
  input  logic [63:0] rt_value,
  input  logic [3:0]  flags,
  input  logic        flags_valid,
  output logic [63:0] pc,
  output logic        flush,
  output logic        seq_stall,
  output logic        link_we,
  output logic [63:0] link_value
);

  localparam logic [0:0] S_RUN        = 1'b0;
  localparam logic [0:0] S_WAIT_FLAGS = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_next_state;
  logic [63:0] r_pc;
  logic [63:0] r_pc_d;
  logic        r_id_valid;

  logic        w_is_b;
  logic        w_is_bl;
  logic        w_is_cbz;
  logic        w_is_cbnz;
  logic        w_is_bcond;
  logic        w_is_br;
  logic        w_cond_true;
  logic        w_taken;
  logic [63:0] w_off26;
  logic [63:0] w_off19;
  logic [63:0] w_target;
  logic        w_flush;
  logic        w_seq_stall;
  logic        w_link_we;

  // Decode is qualified by id_valid so a squashed slot never acts.
  assign w_is_b     = r_id_valid && (instr[31:26] == 6'b000101);
  assign w_is_bl    = r_id_valid && (instr[31:26] == 6'b100101);
  assign w_is_cbz   = r_id_valid && (instr[31:24] == 8'b10110100);
  assign w_is_cbnz  = r_id_valid && (instr[31:24] == 8'b10110101);
  assign w_is_bcond = r_id_valid && (instr[31:24] == 8'b01010100);
  assign w_is_br    = r_id_valid && (instr[31:21] == 11'b11010110000);

  assign w_off26 = {{36{instr[25]}}, instr[25:0], 2'b00};
  assign w_off19 = {{43{instr[23]}}, instr[23:5], 2'b00};

  always_comb begin
    w_cond_true = 1'b1;
    case (instr[3:0])
      4'h0:    w_cond_true =  flags[2];
      4'h1:    w_cond_true = !flags[2];
      4'h2:    w_cond_true =  flags[1];
      4'h3:    w_cond_true = !flags[1];
      4'h4:    w_cond_true =  flags[3];
      4'h5:    w_cond_true = !flags[3];
      4'h6:    w_cond_true =  flags[0];
      4'h7:    w_cond_true = !flags[0];
      4'h8:    w_cond_true =  (flags[1] && !flags[2]);
      4'h9:    w_cond_true = !(flags[1] && !flags[2]);
      4'hA:    w_cond_true =  (flags[3] == flags[0]);
      4'hB:    w_cond_true =  (flags[3] != flags[0]);
      4'hC:    w_cond_true =  (!flags[2] && (flags[3] == flags[0]));
      4'hD:    w_cond_true = !(!flags[2] && (flags[3] == flags[0]));
      default: w_cond_true = 1'b1;
    endcase
  end

  assign w_taken = w_is_b || w_is_bl || w_is_br
                || (w_is_cbz   && (rt_value == 64'd0))
                || (w_is_cbnz  && (rt_value != 64'd0))
                || (w_is_bcond && w_cond_true);

  always_comb begin
    w_target = r_pc_d + w_off26;
    if (w_is_br)
      w_target = rt_value;
    else if (w_is_cbz || w_is_cbnz || w_is_bcond)
      w_target = r_pc_d + w_off19;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_RUN;
    else
      r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    if (!stall) begin
      case (r_state)
        S_RUN:        if (w_is_bcond && !flags_valid) w_next_state = S_WAIT_FLAGS;
        S_WAIT_FLAGS: if (flags_valid) w_next_state = S_RUN;
        default:      w_next_state = S_RUN;
      endcase
    end
  end

  // Output logic; stall suppresses any resolution side effect.
  always_comb begin
    w_seq_stall = 1'b0;
    w_flush     = 1'b0;
    w_link_we   = 1'b0;
    case (r_state)
      S_RUN:        w_seq_stall = w_is_bcond && !flags_valid;
      S_WAIT_FLAGS: w_seq_stall = !flags_valid;
      default:      w_seq_stall = 1'b0;
    endcase
    if (!stall && !w_seq_stall) begin
      w_flush   = w_taken;
      w_link_we = w_is_bl;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_pc_d     <= 64'd0;
      r_id_valid <= 1'b0;
    end else if (!stall && !w_seq_stall) begin
      if (w_taken) begin
        r_pc       <= w_target;
        r_id_valid <= 1'b0;
      end else begin
        r_pc       <= r_pc + 64'd4;
        r_pc_d     <= r_pc;
        r_id_valid <= 1'b1;
      end
    end
  end

  assign pc         = r_pc;
  assign flush      = w_flush;
  assign seq_stall  = w_seq_stall;
  assign link_we    = w_link_we;
  assign link_value = r_pc_d + 64'd4;

endmodule
`default_nettype wire
